alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  controller can accept an instruction
- in_funct  in  6  R-type funct field
- in_rs_val  in  32  operand A value
- in_rt_val  in  32  operand B value
- in_rd  in  5  destination register index
- alu_a  out  32  operand A driven to the external combinational ALU
- alu_b  out  32  operand B driven to the ALU
- alu_op  out  4  ALU opcode
- alu_shamt  out  4  shift amount; tied to 0
- alu_r  in  32  ALU result
- wb_valid  out  1  writeback offered
- wb_ready  in  1  writeback accepted
- wb_rd  out  5  destination index
- wb_data  out  32  result
- wb_zero  out  1  result equals 0
- wb_ovf  out  1  signed overflow flag
- err_illegal  out  1  one-cycle pulse: unknown funct
- err_ovf  out  1  one-cycle pulse: overflow trap (macro-dependent)

Function
REQ-002 SHALL implement the FSM IDLE -> DECODE -> EXEC -> WB -> IDLE.
REQ-003 IDLE: in_ready=1; when in_valid&in_ready, SHALL capture funct, rs, rt and rd, then move to DECODE; in_ready=0 in all other states.
REQ-004 DECODE SHALL map funct to alu_op: 0x20->0001 add, 0x22->0010 sub, 0x24->0011 and, 0x25->0100 or, 0x26->0101 xor.
REQ-005 Any other funct SHALL pulse err_illegal for one cycle, discard the transaction, and return to IDLE with no writeback.
REQ-006 EXEC: alu_a, alu_b and alu_op SHALL be held stable for the whole cycle; alu_r is sampled at the EXEC->WB edge.
REQ-007 In all states other than EXEC, alu_op SHALL be 4'b0000 and alu_a/alu_b SHALL be 0.
REQ-008 wb_zero SHALL be computed locally as (sampled result == 0).
REQ-009 wb_ovf SHALL be computed locally:
- add: sign(a)==sign(b) and sign(r)!=sign(a)
- sub: sign(a)!=sign(b) and sign(r)!=sign(a)
- logical ops: 0
REQ-010 Arithmetic SHALL be 32-bit modulo 2^32.
REQ-011 If rd==0, wb_data and wb_zero SHALL be forced to 0 and 1 respectively; the writeback is still issued.
REQ-012 WB: wb_valid=1; wb_rd, wb_data, wb_zero and wb_ovf SHALL stay stable until the cycle wb_valid&wb_ready; the FSM then returns to IDLE.
REQ-013 Latency: handshake accepted in cycle N, wb_valid first high in cycle N+3; the earliest next acceptance is cycle N+4.
REQ-014 in_valid SHALL be ignored outside IDLE; a held in_valid is accepted on the next IDLE cycle.

Reset
REQ-015 rst_n low at a clock edge SHALL force IDLE from any state and discard the in-flight transaction.
REQ-016 During and after reset, all outputs SHALL be 0 except in_ready, which SHALL be 1 in the first cycle after rst_n returns high.
REQ-017 A reset during WB SHALL drop wb_valid on the next edge without requiring wb_ready.

Configuration
REQ-018 Macro ALU_OVERFLOW_TRAP_EN, when defined: an op with overflow SHALL skip WB, pulse err_ovf for one cycle, and return to IDLE.
REQ-019 When ALU_OVERFLOW_TRAP_EN is undefined: err_ovf SHALL be tied to 0, and overflow results SHALL be written back with wb_ovf=1.

Structure
REQ-020 A shared package alu_ctrl_pkg SHALL hold the ALU opcode constants, the funct constants and the FSM state encoding.
REQ-021 The funct-to-opcode mapping plus illegal detection SHALL be a combinational sub-module alu_funct_decoder.
REQ-022 The ALU itself SHALL remain external and connect only via alu_a, alu_b, alu_op, alu_shamt and alu_r.

Verification
REQ-023 add: rs=5, rt=7, funct=0x20, rd=3 -> wb_valid at N+3 with wb_data=12, wb_zero=0, wb_ovf=0, wb_rd=3.
REQ-024 sub overflow: rs=0x80000000, rt=1, funct=0x22 -> wb_ovf=1 (macro undefined); with the macro defined -> err_ovf pulse and no wb_valid.
REQ-025 Illegal: funct=0x27 -> err_illegal high for exactly one cycle at N+1; in_ready=1 again at N+2.
REQ-026 Backpressure: xor rs=0xFFFF0000, rt=0xFFFF0000, wb_ready=0 for 5 cycles -> wb_data=0 and wb_zero=1 held stable; a second in_valid is not accepted until after the handshake.
REQ-027 Reset in EXEC, then rd=0 with and: rs=0xF, rt=0xF -> the first transaction produces no writeback; the second gives wb_data=0, wb_zero=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Purpose : shared opcode, funct and FSM-state constants plus the issue/writeback records.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package alu_ctrl_pkg;

    // Opcodes understood by the external ALU
    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;

    // R-type funct encodings accepted by the controller
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;

    // Issue FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_WB     = 2'd3;

    // Instruction captured at the input handshake
    typedef struct packed {
        logic [5:0]  funct;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  rd;
    } issue_t;

    // Writeback payload frozen at the EXEC->WB edge
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        zero;
        logic        ovf;
    } wb_t;

    // Signed overflow from operand/result sign bits; logical ops never overflow.
    function automatic logic signed_ovf(input logic [3:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] r);
        logic ovf;
        case (op)
            OP_ADD:  ovf = (a[31] == b[31]) && (r[31] != a[31]);
            OP_SUB:  ovf = (a[31] != b[31]) && (r[31] != a[31]);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

endpackage

// File: rtl/alu_funct_decoder.sv
// Purpose : maps an R-type funct field to an ALU opcode and flags unknown functs.
// Latency : combinational.
// Backpressure: none.
// Ports: funct_i (6b funct) -> op_o (4b ALU opcode, OP_NONE when illegal), illegal_o.
module alu_funct_decoder
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] op_o,
    output logic       illegal_o
);

    always_comb begin
        op_o      = OP_NONE;
        illegal_o = 1'b0;
        case (funct_i)
            FUNCT_ADD: op_o = OP_ADD;
            FUNCT_SUB: op_o = OP_SUB;
            FUNCT_AND: op_o = OP_AND;
            FUNCT_OR:  op_o = OP_OR;
            FUNCT_XOR: op_o = OP_XOR;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Purpose : single-issue controller sequencing one R-type op through an external ALU to writeback.
// Latency : accept in cycle N, wb_valid in N+3, next accept no earlier than N+4.
// Backpressure: one instruction in flight; in_ready low outside IDLE, WB holds until wb_ready.
// Ports: clk/rst_n (sync active-low); in_* issue handshake and operands; alu_* to/from the
//        external combinational ALU; wb_* writeback handshake and flags; err_illegal/err_ovf pulses.
// Config: define ALU_OVERFLOW_TRAP_EN to trap overflowing ops (no writeback, err_ovf pulse);
//         otherwise overflow is reported through wb_ovf and err_ovf is tied low.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic [4:0]  in_rd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_shamt,
    input  logic [31:0] alu_r,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_zero,
    output logic        wb_ovf,
    output logic        err_illegal,
    output logic        err_ovf
);

    logic [1:0] state_q, state_d;
    issue_t     instr_q;
    logic [3:0] op_q;
    wb_t        wb_q;

    logic [3:0] dec_op;
    logic       dec_illegal;
    logic       is_idle, is_decode, is_exec, is_wb;
    logic       accept;
    logic       exec_ovf;
    logic       rd_zero;

    alu_funct_decoder u_decoder (
        .funct_i   (instr_q.funct),
        .op_o      (dec_op),
        .illegal_o (dec_illegal)
    );

    assign is_idle   = (state_q == ST_IDLE);
    assign is_decode = (state_q == ST_DECODE);
    assign is_exec   = (state_q == ST_EXEC);
    assign is_wb     = (state_q == ST_WB);

    assign accept    = in_valid & in_ready;
    assign exec_ovf  = signed_ovf(op_q, instr_q.rs, instr_q.rt, alu_r);
    assign rd_zero   = (instr_q.rd == 5'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_DECODE;
            ST_DECODE: state_d = dec_illegal ? ST_IDLE : ST_EXEC;
`ifdef ALU_OVERFLOW_TRAP_EN
            ST_EXEC:   state_d = exec_ovf ? ST_IDLE : ST_WB;
`else
            ST_EXEC:   state_d = ST_WB;
`endif
            ST_WB:     if (wb_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            op_q    <= OP_NONE;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q.funct <= in_funct;
                instr_q.rs    <= in_rs_val;
                instr_q.rt    <= in_rt_val;
                instr_q.rd    <= in_rd;
            end
            if (is_decode) begin
                op_q <= dec_op;
            end
            // alu_r is sampled here, at the EXEC->WB edge; r0 writes read back as zero.
            if (is_exec) begin
                wb_q.rd   <= instr_q.rd;
                wb_q.data <= rd_zero ? 32'd0 : alu_r;
                wb_q.zero <= rd_zero | (alu_r == 32'd0);
                wb_q.ovf  <= exec_ovf;
            end
        end
    end

    // in_ready is masked by rst_n so it stays low while reset is held.
    assign in_ready    = is_idle & rst_n;

    // ALU operands are only presented during EXEC, zero elsewhere.
    assign alu_a       = is_exec ? instr_q.rs : 32'd0;
    assign alu_b       = is_exec ? instr_q.rt : 32'd0;
    assign alu_op      = is_exec ? op_q : OP_NONE;
    assign alu_shamt   = 4'd0;

    assign wb_valid    = is_wb;
    assign wb_rd       = is_wb ? wb_q.rd   : 5'd0;
    assign wb_data     = is_wb ? wb_q.data : 32'd0;
    assign wb_zero     = is_wb & wb_q.zero;
    assign wb_ovf      = is_wb & wb_q.ovf;

    assign err_illegal = is_decode & dec_illegal;
`ifdef ALU_OVERFLOW_TRAP_EN
    assign err_ovf     = is_exec & exec_ovf;
`else
    assign err_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Purpose : self-checking bench for alu_issue_ctrl with a behavioural ALU and reference model.
// Latency : n/a.
// Backpressure: wb_ready driven directly and randomly.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [4:0]  in_rd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [3:0]  alu_shamt;
    logic [31:0] alu_r;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_zero;
    logic        wb_ovf;
    logic        err_illegal;
    logic        err_ovf;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct    (in_funct),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .in_rd       (in_rd),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_shamt   (alu_shamt),
        .alu_r       (alu_r),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_zero     (wb_zero),
        .wb_ovf      (wb_ovf),
        .err_illegal (err_illegal),
        .err_ovf     (err_ovf)
    );

    // External combinational ALU
    always_comb begin
        case (alu_op)
            4'd1:    alu_r = alu_a + alu_b;
            4'd2:    alu_r = alu_a - alu_b;
            4'd3:    alu_r = alu_a & alu_b;
            4'd4:    alu_r = alu_a | alu_b;
            4'd5:    alu_r = alu_a ^ alu_b;
            default: alu_r = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference result: overflow means the exact signed result does not fit in 32 bits.
    function automatic void ref_calc(input  logic [5:0]  f,
                                     input  logic [31:0] a,
                                     input  logic [31:0] b,
                                     output logic        legal,
                                     output logic [3:0]  op,
                                     output logic [31:0] r,
                                     output logic        ovf);
        longint sa, sb, w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        w = 0;
        legal = 1'b1;
        op = 4'd0;
        r = 32'd0;
        ovf = 1'b0;
        case (f)
            6'h20: begin op = 4'd1; w = sa + sb; r = w[31:0]; ovf = (w != longint'($signed(r))); end
            6'h22: begin op = 4'd2; w = sa - sb; r = w[31:0]; ovf = (w != longint'($signed(r))); end
            6'h24: begin op = 4'd3; r = a & b; end
            6'h25: begin op = 4'd4; r = a | b; end
            6'h26: begin op = 4'd5; r = a ^ b; end
            default: legal = 1'b0;
        endcase
    endfunction

    // Model: at most one instruction in flight, tracked by its age in cycles since acceptance.
    bit          m_live = 1'b0;
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    logic [5:0]  m_funct = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [4:0]  m_rd = '0;

    initial begin : model
        logic        legal, ovf;
        logic [3:0]  op;
        logic [31:0] r;
        logic        e_rdy, e_wbv, e_zero, e_ovf, e_ill, e_eovf;
        logic [31:0] e_a, e_b, e_data;
        logic [3:0]  e_op;
        logic [4:0]  e_rd;
        logic [114:0] act, exp;
        forever begin
            @(posedge clk);
            ref_calc(m_funct, m_a, m_b, legal, op, r, ovf);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_live = 1'b1;
            end else if (m_live) begin
                if (!m_busy) begin
                    if (in_valid) begin
                        m_busy = 1'b1; m_age = 1;
                        m_funct = in_funct; m_a = in_rs_val; m_b = in_rt_val; m_rd = in_rd;
                    end
                end else if (m_age == 1) begin
                    if (!legal) m_busy = 1'b0;
                    else m_age = 2;
                end else if (m_age == 2) begin
`ifdef ALU_OVERFLOW_TRAP_EN
                    if (ovf) m_busy = 1'b0;
                    else m_age = 3;
`else
                    m_age = 3;
`endif
                end else if (wb_ready) begin
                    m_busy = 1'b0;
                end
            end
            @(negedge clk);
            if (m_live) begin
                ref_calc(m_funct, m_a, m_b, legal, op, r, ovf);
                e_rdy = 1'b0; e_wbv = 1'b0; e_zero = 1'b0; e_ovf = 1'b0; e_ill = 1'b0; e_eovf = 1'b0;
                e_a = '0; e_b = '0; e_data = '0; e_op = '0; e_rd = '0;
                if (!m_busy) begin
                    e_rdy = rst_n;
                end else if (m_age == 1) begin
                    e_ill = !legal;
                end else if (m_age == 2) begin
                    e_a = m_a; e_b = m_b; e_op = op;
`ifdef ALU_OVERFLOW_TRAP_EN
                    e_eovf = ovf;
`endif
                end else begin
                    e_wbv = 1'b1; e_rd = m_rd; e_ovf = ovf;
                    e_data = (m_rd == 5'd0) ? 32'd0 : r;
                    e_zero = (m_rd == 5'd0) || (r == 32'd0);
                end
                exp = {e_rdy, e_a, e_b, e_op, 4'd0, e_wbv, e_rd, e_data, e_zero, e_ovf, e_ill, e_eovf};
                act = {in_ready, alu_a, alu_b, alu_op, alu_shamt, wb_valid, wb_rd, wb_data,
                       wb_zero, wb_ovf, err_illegal, err_ovf};
                checks++;
                if (act === exp) passes++;
                else $display("FAIL cycle_model t=%0t: got %h, expected %h", $time, act, exp);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge (cycle N+1).
    task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d);
        int n;
        n = 0;
        in_valid = 1'b1; in_funct = f; in_rs_val = a; in_rt_val = b; in_rd = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin : stim
        logic [5:0] legal_f [5];
        legal_f[0] = 6'h20; legal_f[1] = 6'h22; legal_f[2] = 6'h24;
        legal_f[3] = 6'h25; legal_f[4] = 6'h26;
        rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
        in_funct = '0; in_rs_val = '0; in_rt_val = '0; in_rd = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_flags", {24'd0, wb_valid, err_illegal, err_ovf, wb_zero, alu_op}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // add 5+7 -> rd 3
        @(posedge clk); #1;
        send(6'h20, 32'd5, 32'd7, 5'd3);
        @(negedge clk); chk("add_wbv_n1", {31'd0, wb_valid}, 32'd0);
        @(negedge clk); chk("add_alu_a", alu_a, 32'd5); chk("add_alu_b", alu_b, 32'd7);
                        chk("add_alu_op", {28'd0, alu_op}, 32'd1);
        @(negedge clk); chk("add_wbv_n3", {31'd0, wb_valid}, 32'd1);
                        chk("add_data", wb_data, 32'd12); chk("add_rd", {27'd0, wb_rd}, 32'd3);
                        chk("add_zero_ovf", {30'd0, wb_zero, wb_ovf}, 32'd0);
        @(negedge clk); chk("add_ready_n4", {31'd0, in_ready}, 32'd1);

        // sub overflow
        @(posedge clk); #1;
        send(6'h22, 32'h8000_0000, 32'd1, 5'd4);
        @(negedge clk);
        @(negedge clk);
`ifdef ALU_OVERFLOW_TRAP_EN
        chk("sub_err_ovf", {31'd0, err_ovf}, 32'd1);
        @(negedge clk); chk("sub_trap_no_wb", {31'd0, wb_valid}, 32'd0);
`else
        chk("sub_err_ovf_tied", {31'd0, err_ovf}, 32'd0);
        @(negedge clk); chk("sub_wbv", {31'd0, wb_valid}, 32'd1);
                        chk("sub_ovf", {31'd0, wb_ovf}, 32'd1);
                        chk("sub_data", wb_data, 32'h7FFF_FFFF);
`endif

        // illegal funct
        @(posedge clk); #1;
        send(6'h27, 32'd1, 32'd2, 5'd9);
        @(negedge clk); chk("ill_pulse", {31'd0, err_illegal}, 32'd1);
        @(negedge clk); chk("ill_pulse_end", {31'd0, err_illegal}, 32'd0);
                        chk("ill_ready_n2", {31'd0, in_ready}, 32'd1);
                        chk("ill_no_wb", {31'd0, wb_valid}, 32'd0);

        // backpressure on xor result, second instruction held
        @(posedge clk); #1; wb_ready = 1'b0;
        send(6'h26, 32'hFFFF_0000, 32'hFFFF_0000, 5'd7);
        in_valid = 1'b1; in_funct = 6'h20; in_rs_val = 32'd1; in_rt_val = 32'd2; in_rd = 5'd1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_wbv", {31'd0, wb_valid}, 32'd1);
            chk("bp_data", wb_data, 32'd0);
            chk("bp_zero_rd", {26'd0, wb_zero, wb_rd}, {26'd0, 1'b1, 5'd7});
            chk("bp_no_accept", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1; wb_ready = 1'b1;
        @(negedge clk); chk("bp_wbv_last", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); chk("bp_second_data", wb_data, 32'd3);
                        chk("bp_second_rd", {27'd0, wb_rd}, 32'd1);

        // reset in EXEC, then and with rd=0
        @(posedge clk); #1;
        send(6'h24, 32'hF, 32'hF, 5'd5);
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk); chk("rst_exec_op", {28'd0, alu_op}, 32'd3);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); chk("rst_exec_no_wb", {31'd0, wb_valid}, 32'd0);
                        chk("rst_exec_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        send(6'h24, 32'hF, 32'hF, 5'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); chk("rd0_wbv", {31'd0, wb_valid}, 32'd1);
                        chk("rd0_data", wb_data, 32'd0);
                        chk("rd0_zero", {31'd0, wb_zero}, 32'd1);

        // reset while stalled in WB
        @(posedge clk); #1; wb_ready = 1'b0;
        send(6'h20, 32'd1, 32'd1, 5'd2);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk); chk("rst_wb_before", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1; rst_n = 1'b1; wb_ready = 1'b1;
        @(negedge clk); chk("rst_wb_dropped", {31'd0, wb_valid}, 32'd0);
                        chk("rst_wb_ready", {31'd0, in_ready}, 32'd1);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst_n     = ($urandom_range(0, 99) >= 2);
            in_valid  = ($urandom_range(0, 99) < 60);
            wb_ready  = ($urandom_range(0, 99) < 50);
            case ($urandom_range(0, 7))
                5, 6:    in_funct = 6'($urandom);
                7:       in_funct = 6'h27;
                default: in_funct = legal_f[$urandom_range(0, 4)];
            endcase
            in_rs_val = rand_opnd();
            in_rt_val = rand_opnd();
            in_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        end

        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; wb_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
